// File: rtl/hwpe_stream_fifo_thr.sv
// hwpe_stream_fifo_thr
//   Stream FIFO with optional zero-latency fall-through path, occupancy count
//   and threshold status flags.
//
//   Optional feature macro: HWPE_STREAM_FIFO_THR_PEAK_EN adds peak_o, the
//   high-water mark of count_o since the last reset or clear.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   clear_i                 synchronous flush, discards same-cycle handshakes
//   push_valid_i/ready_o    input stream handshake
//   push_data_i/strb_i      input payload and byte strobes
//   pop_valid_o/ready_i     output stream handshake
//   pop_data_o/strb_o       oldest entry (all-zero when pop_valid_o is low)
//   count_o                 stored entry count
//   empty_o, full_o         count_o == 0 / count_o == FIFO_DEPTH
//   almost_empty_o          count_o <= AE_THRESH
//   almost_full_o           count_o >= AF_THRESH
//   peak_o                  high-water mark (macro build only)
module hwpe_stream_fifo_thr #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned FALL_THROUGH = 0,
  parameter int unsigned AF_THRESH    = FIFO_DEPTH - 1,
  parameter int unsigned AE_THRESH    = 1,
  localparam int unsigned STRB_W      = DATA_WIDTH / 8,
  localparam int unsigned CW          = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  push_valid_i,
  output logic                  push_ready_o,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic [STRB_W-1:0]     push_strb_i,
  output logic                  pop_valid_o,
  input  logic                  pop_ready_i,
  output logic [DATA_WIDTH-1:0] pop_data_o,
  output logic [STRB_W-1:0]     pop_strb_o,
  output logic [CW-1:0]         count_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  almost_empty_o,
  output logic                  almost_full_o
`ifdef HWPE_STREAM_FIFO_THR_PEAK_EN
  ,
  output logic [CW-1:0]         peak_o
`endif
);

  localparam int unsigned PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned EW   = DATA_WIDTH + STRB_W;
  localparam bit          FT   = (FALL_THROUGH != 0);
  localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);

  if (FIFO_DEPTH < 2) begin : g_err_depth
    $error("hwpe_stream_fifo_thr: FIFO_DEPTH must be >= 2");
  end
  if (AF_THRESH > FIFO_DEPTH) begin : g_err_af
    $error("hwpe_stream_fifo_thr: AF_THRESH must be <= FIFO_DEPTH");
  end
  if (AE_THRESH >= FIFO_DEPTH) begin : g_err_ae
    $error("hwpe_stream_fifo_thr: AE_THRESH must be < FIFO_DEPTH");
  end
  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH == 0) begin : g_err_dw
    $error("hwpe_stream_fifo_thr: DATA_WIDTH must be a non-zero multiple of 8");
  end

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  logic stored_valid;
  logic push_hs, pop_hs, bypass;
  logic wr_en, rd_en;

  assign stored_valid   = (count_q != '0);
  assign push_ready_o   = (count_q < CW'(FIFO_DEPTH));
  assign count_o        = count_q;
  assign empty_o        = (count_q == '0);
  assign full_o         = (count_q == CW'(FIFO_DEPTH));
  assign almost_full_o  = (count_q >= CW'(AF_THRESH));
  assign almost_empty_o = (count_q <= CW'(AE_THRESH));

  // Output mux: on an empty fall-through FIFO the input stream is presented
  // directly; otherwise the head slot, forced to zero when nothing is valid.
  always_comb begin
    pop_valid_o = stored_valid;
    pop_data_o  = '0;
    pop_strb_o  = '0;
    if (FT && !stored_valid) begin
      pop_valid_o = push_valid_i;
      if (push_valid_i) begin
        pop_data_o = push_data_i;
        pop_strb_o = push_strb_i;
      end
    end else if (stored_valid) begin
      {pop_strb_o, pop_data_o} = mem_q[rptr_q];
    end
  end

  // A simultaneous push/pop on an empty fall-through FIFO is served by the
  // bypass mux alone, so storage, pointers and count stay untouched.
  always_comb begin
    push_hs = push_valid_i & push_ready_o;
    pop_hs  = pop_valid_o & pop_ready_i;
    bypass  = FT & ~stored_valid & push_hs & pop_hs;
    wr_en   = push_hs & ~bypass & ~clear_i & ~rst_i;
    rd_en   = pop_hs & ~bypass & ~clear_i;
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clear_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_en) begin
        wptr_d = (wptr_q == LAST) ? '0 : wptr_q + PW'(1);
      end
      if (rd_en) begin
        rptr_d = (rptr_q == LAST) ? '0 : rptr_q + PW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset: a slot is only ever presented after being written.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wptr_q] <= {push_strb_i, push_data_i};
    end
  end

`ifdef HWPE_STREAM_FIFO_THR_PEAK_EN
  logic [CW-1:0] peak_q, peak_d;

  always_comb begin
    peak_d = peak_q;
    if (clear_i) begin
      peak_d = '0;
    end else if (count_d > peak_q) begin
      peak_d = count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak_o = peak_q;
`endif

endmodule

// File: tb/tb_hwpe_stream_fifo_thr.sv
// Testbench for hwpe_stream_fifo_thr: two instances (FALL_THROUGH 0 and 1)
// driven by the same stimulus, each compared against its own queue model.
module tb_hwpe_stream_fifo_thr;

  localparam int unsigned DEPTH = 5;
  localparam int unsigned OW    = 45;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr, pv, pr;
  logic [31:0] pd;
  logic [3:0]  ps;

  logic        m_prdy, m_pvld, m_emp, m_full, m_ae, m_af;
  logic [31:0] m_data;
  logic [3:0]  m_strb;
  logic [2:0]  m_cnt, m_peak;
  logic        f_prdy, f_pvld, f_emp, f_full, f_ae, f_af;
  logic [31:0] f_data;
  logic [3:0]  f_strb;
  logic [2:0]  f_cnt, f_peak;

  hwpe_stream_fifo_thr #(
    .DATA_WIDTH(32), .FIFO_DEPTH(DEPTH), .FALL_THROUGH(0), .AF_THRESH(4), .AE_THRESH(1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clr),
    .push_valid_i(pv), .push_ready_o(m_prdy), .push_data_i(pd), .push_strb_i(ps),
    .pop_valid_o(m_pvld), .pop_ready_i(pr), .pop_data_o(m_data), .pop_strb_o(m_strb),
    .count_o(m_cnt), .empty_o(m_emp), .full_o(m_full),
    .almost_empty_o(m_ae), .almost_full_o(m_af)
`ifdef HWPE_STREAM_FIFO_THR_PEAK_EN
    , .peak_o(m_peak)
`endif
  );

  hwpe_stream_fifo_thr #(
    .DATA_WIDTH(32), .FIFO_DEPTH(DEPTH), .FALL_THROUGH(1), .AF_THRESH(4), .AE_THRESH(1)
  ) dut_ft (
    .clk_i(clk), .rst_i(rst), .clear_i(clr),
    .push_valid_i(pv), .push_ready_o(f_prdy), .push_data_i(pd), .push_strb_i(ps),
    .pop_valid_o(f_pvld), .pop_ready_i(pr), .pop_data_o(f_data), .pop_strb_o(f_strb),
    .count_o(f_cnt), .empty_o(f_emp), .full_o(f_full),
    .almost_empty_o(f_ae), .almost_full_o(f_af)
`ifdef HWPE_STREAM_FIFO_THR_PEAK_EN
    , .peak_o(f_peak)
`endif
  );

`ifndef HWPE_STREAM_FIFO_THR_PEAK_EN
  assign m_peak = '0;
  assign f_peak = '0;
`endif

  logic [OW-1:0] obs_m, obs_f;
  assign obs_m = {m_prdy, m_pvld, m_strb, m_data, m_cnt, m_emp, m_full, m_ae, m_af};
  assign obs_f = {f_prdy, f_pvld, f_strb, f_data, f_cnt, f_emp, f_full, f_ae, f_af};

  // Reference model: ordered queues of {strb,data}, plus high-water marks.
  logic [35:0] qm[$];
  logic [35:0] qf[$];
  int unsigned pk_m, pk_f;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  function automatic logic [OW-1:0] exp_vec(input bit ft);
    int unsigned n;
    logic        vld;
    logic [35:0] word;
    n    = ft ? qf.size() : qm.size();
    word = '0;
    vld  = (n > 0);
    if (n > 0) word = ft ? qf[0] : qm[0];
    if (ft && n == 0) begin
      vld  = pv;
      word = pv ? {ps, pd} : 36'h0;
    end
    return {n < DEPTH, vld, word, 3'(n), n == 0, n == DEPTH, n <= 1, n >= 4};
  endfunction

  // Advance the model by the rules of one clock edge, then the clock itself.
  task automatic tick();
    int unsigned n;
    bit phs, pops;
    n = qm.size();
    if (rst || clr) begin
      qm.delete(); pk_m = 0;
    end else begin
      phs  = pv && (n < DEPTH);
      pops = pr && (n > 0);
      if (pops) void'(qm.pop_front());
      if (phs) qm.push_back({ps, pd});
      if (qm.size() > pk_m) pk_m = qm.size();
    end
    n = qf.size();
    if (rst || clr) begin
      qf.delete(); pk_f = 0;
    end else begin
      phs  = pv && (n < DEPTH);
      pops = (n == 0) ? (pr && pv) : pr;
      if (!(n == 0 && pops)) begin
        if (pops) void'(qf.pop_front());
        if (phs) qf.push_back({ps, pd});
      end
      if (qf.size() > pk_f) pk_f = qf.size();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] s, input logic r);
    pv = v; pd = d; ps = s; pr = r;
    #1;
  endtask

  task automatic do_clear();
    clr = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 32'hDEAD, 4'hF, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    n_checks++;
    if (obs_m !== {1'b1, 1'b0, 36'h0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0})
      $display("FAIL reset_main got %h exp %h", obs_m, {1'b1, 1'b0, 36'h0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0});
    else n_pass++;
    n_checks++;
    if (obs_f !== exp_vec(1)) $display("FAIL reset_ft got %h exp %h", obs_f, exp_vec(1));
    else n_pass++;
    n_checks++;
    if (m_peak !== 3'd0) $display("FAIL reset_peak got %0d exp 0", m_peak);
    else n_pass++;
  endtask

  task automatic test_fill();
    do_clear();
    for (int unsigned i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'hA0 + i, 4'hF, 1'b0);
      n_checks++;
      if (obs_m !== exp_vec(0)) $display("FAIL fill_push%0d got %h exp %h", i, obs_m, exp_vec(0));
      else n_pass++;
      if (i == 4) begin
        n_checks++;
        if (m_af !== 1'b1) $display("FAIL fill_af_at4 got %b exp 1", m_af);
        else n_pass++;
      end
      tick();
    end
    drive(1'b1, 32'hEE, 4'hF, 1'b0);
    n_checks++;
    if ({m_cnt, m_full, m_prdy} !== {3'd5, 1'b1, 1'b0})
      $display("FAIL fill_full got %h exp %h", {m_cnt, m_full, m_prdy}, {3'd5, 1'b1, 1'b0});
    else n_pass++;
    tick();
    for (int unsigned i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, '0, 1'b1);
      n_checks++;
      if ({m_pvld, m_data} !== {1'b1, 32'hA0 + i})
        $display("FAIL fill_pop%0d got %h exp %h", i, {m_pvld, m_data}, {1'b1, 32'hA0 + i});
      else n_pass++;
      tick();
    end
    drive(1'b0, '0, '0, 1'b1);
    n_checks++;
    if (obs_m !== exp_vec(0)) $display("FAIL fill_drained got %h exp %h", obs_m, exp_vec(0));
    else n_pass++;
  endtask

  task automatic test_wrap();
    int unsigned pushed, popped;
    bit          ok;
    pushed = 0; popped = 0; ok = 1'b1;
    do_clear();
    for (int unsigned cyc = 0; cyc < 60 && popped < 12; cyc++) begin
      drive(pushed < 12, 32'(pushed), 4'hF, (cyc % 3) != 0);
      if (obs_m !== exp_vec(0)) ok = 1'b0;
      if (pr && qm.size() > 0) begin
        n_checks++;
        if (m_data !== 32'(popped)) $display("FAIL wrap_pop%0d got %h exp %h", popped, m_data, 32'(popped));
        else n_pass++;
        popped++;
      end
      if (pv && qm.size() < DEPTH) pushed++;
      tick();
    end
    n_checks++;
    if (!ok || popped != 12) $display("FAIL wrap_done got popped=%0d flags_ok=%0d exp popped=12 flags_ok=1", popped, ok);
    else n_pass++;
  endtask

  task automatic test_full_pop();
    do_clear();
    for (int unsigned i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'hC0 + i, 4'h3, 1'b0);
      tick();
    end
    drive(1'b1, 32'hB0, 4'hF, 1'b1);
    n_checks++;
    if ({m_prdy, m_pvld, m_data} !== {1'b0, 1'b1, 32'hC0})
      $display("FAIL fullpop_hs got %h exp %h", {m_prdy, m_pvld, m_data}, {1'b0, 1'b1, 32'hC0});
    else n_pass++;
    tick();
    drive(1'b1, 32'hB1, 4'hF, 1'b0);
    n_checks++;
    if ({m_cnt, m_prdy} !== {3'd4, 1'b1}) $display("FAIL fullpop_cnt got %h exp %h", {m_cnt, m_prdy}, {3'd4, 1'b1});
    else n_pass++;
    tick();
    drive(1'b0, '0, '0, 1'b0);
    n_checks++;
    if ({m_cnt, m_full} !== {3'd5, 1'b1}) $display("FAIL fullpop_refill got %h exp %h", {m_cnt, m_full}, {3'd5, 1'b1});
    else n_pass++;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, '0, 1'b1);
      n_checks++;
      if (obs_m !== exp_vec(0)) $display("FAIL fullpop_drain%0d got %h exp %h", i, obs_m, exp_vec(0));
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_fall_through();
    do_clear();
    drive(1'b1, 32'h55, 4'hF, 1'b1);
    n_checks++;
    if ({f_pvld, f_data, f_strb} !== {1'b1, 32'h55, 4'hF})
      $display("FAIL ft_bypass got %h exp %h", {f_pvld, f_data, f_strb}, {1'b1, 32'h55, 4'hF});
    else n_pass++;
    n_checks++;
    if (m_pvld !== 1'b0) $display("FAIL ft_nonft_latency got %b exp 0", m_pvld);
    else n_pass++;
    tick();
    drive(1'b0, '0, '0, 1'b0);
    n_checks++;
    if ({f_cnt, f_emp, f_pvld, f_data} !== {3'd0, 1'b1, 1'b0, 32'h0})
      $display("FAIL ft_count got %h exp %h", {f_cnt, f_emp, f_pvld, f_data}, {3'd0, 1'b1, 1'b0, 32'h0});
    else n_pass++;
    n_checks++;
    if (obs_m !== exp_vec(0)) $display("FAIL ft_main_stored got %h exp %h", obs_m, exp_vec(0));
    else n_pass++;
  endtask

  task automatic test_clear_reset();
    for (int unsigned k = 0; k < 2; k++) begin
      do_clear();
      for (int unsigned i = 0; i < 3; i++) begin
        drive(1'b1, 32'h70 + i, 4'h1, 1'b0);
        tick();
      end
      drive(1'b0, '0, '0, 1'b0);
      n_checks++;
      if (m_cnt !== 3'd3) $display("FAIL clrrst%0d_pre got %0d exp 3", k, m_cnt);
      else n_pass++;
`ifdef HWPE_STREAM_FIFO_THR_PEAK_EN
      n_checks++;
      if (m_peak !== 3'd3) $display("FAIL clrrst%0d_peak_pre got %0d exp 3", k, m_peak);
      else n_pass++;
`endif
      if (k == 0) clr = 1'b1;
      else rst = 1'b1;
      drive(1'b1, 32'h99, 4'hF, 1'b0);
      tick();
      clr = 1'b0;
      rst = 1'b0;
      drive(1'b0, '0, '0, 1'b0);
      n_checks++;
      if ({m_cnt, m_pvld, m_data, m_peak} !== {3'd0, 1'b0, 32'h0, 3'd0})
        $display("FAIL clrrst%0d_post got %h exp %h", k, {m_cnt, m_pvld, m_data, m_peak}, {3'd0, 1'b0, 32'h0, 3'd0});
      else n_pass++;
      n_checks++;
      if (obs_f !== exp_vec(1)) $display("FAIL clrrst%0d_ft got %h exp %h", k, obs_f, exp_vec(1));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    do_clear();
    for (int unsigned cyc = 0; cyc < 400; cyc++) begin
      clr = ($urandom_range(0, 63) == 0);
      drive($urandom_range(0, 3) != 0, $urandom, 4'($urandom), $urandom_range(0, 2) != 0);
      n_checks++;
      if (obs_m !== exp_vec(0)) $display("FAIL rand_main c%0d got %h exp %h", cyc, obs_m, exp_vec(0));
      else n_pass++;
      n_checks++;
      if (obs_f !== exp_vec(1)) $display("FAIL rand_ft c%0d got %h exp %h", cyc, obs_f, exp_vec(1));
      else n_pass++;
`ifdef HWPE_STREAM_FIFO_THR_PEAK_EN
      n_checks++;
      if ({m_peak, f_peak} !== {3'(pk_m), 3'(pk_f)})
        $display("FAIL rand_peak c%0d got %h exp %h", cyc, {m_peak, f_peak}, {3'(pk_m), 3'(pk_f)});
      else n_pass++;
`endif
      tick();
    end
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; pv = 1'b0; pr = 1'b0; pd = '0; ps = '0;
    pk_m = 0; pk_f = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_wrap();
    test_full_pop();
    test_fall_through();
    test_clear_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
